// File: rtl/nios2system_timer_pkg.sv
// Shared definitions for the Nios II interval-timer controller: FSM states,
// timer slave register map and control register bit positions.
package nios2system_timer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLR0,
    WR_PL,
    WR_PH,
    WR_CTL,
    ARMED,
    WR_ST,
    WR_SNAP,
    RD_SL,
    RD_SH,
    CAP_SH,
    STOP
  } timer_state_t;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

endpackage

// File: rtl/nios2system_timer_ctrl_if.sv
// Avalon-MM link between the timer controller (master) and the 16-bit
// interval timer slave; no waitrequest, read data one cycle after address.
interface nios2system_timer_ctrl_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/nios2system_timer_ctrl.sv
// Programs the interval timer, services its timeout irq by snapshotting the
// counter, and stops it on request.
//
// state   | meaning
// IDLE    | no bus activity, waiting for cmd_start
// CLR0    | write STATUS=0
// WR_PL   | write PERIODL = period[15:0]
// WR_PH   | write PERIODH = period[31:16]
// WR_CTL  | write CONTROL = START | cont | ITO
// ARMED   | timer running, waiting for irq or stop
// WR_ST   | write STATUS=0 to clear TO
// WR_SNAP | write SNAPL to latch the counter snapshot
// RD_SL   | read SNAPL
// RD_SH   | read SNAPH, capture low half
// CAP_SH  | capture high half, report the event
// STOP    | write CONTROL = STOP
module nios2system_timer_ctrl
  import nios2system_timer_pkg::*;
#(
  parameter logic P_IRQ_EN = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_start,
  input  logic                            cmd_stop,
  input  logic [31:0]                     cfg_period,
  input  logic                            cfg_continuous,
  nios2system_timer_ctrl_if.master        avm,
  input  logic                            timer_irq,
  output logic                            busy,
  output logic [31:0]                     snap_value,
  output logic                            snap_valid,
  output logic [15:0]                     event_count,
  output logic                            cfg_error
);

  timer_state_t state, state_nxt;
  logic [31:0]  period_q;
  logic         cont_q;
  logic         stop_pending;
  logic         stop_req;

  logic         cs_nxt;
  logic         wn_nxt;
  logic [2:0]   addr_nxt;
  logic [15:0]  data_nxt;

  // A stop arriving in the very cycle of the decision point still counts.
  assign stop_req = stop_pending | cmd_stop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_start && (cfg_period != 32'd0)) state_nxt = CLR0;
      CLR0:    state_nxt = WR_PL;
      WR_PL:   state_nxt = WR_PH;
      WR_PH:   state_nxt = WR_CTL;
      WR_CTL:  state_nxt = stop_req ? STOP : ARMED;
      ARMED: begin
        if (cmd_stop)       state_nxt = STOP;
        else if (timer_irq) state_nxt = WR_ST;
      end
      WR_ST:   state_nxt = WR_SNAP;
      WR_SNAP: state_nxt = RD_SL;
      RD_SL:   state_nxt = RD_SH;
      RD_SH:   state_nxt = CAP_SH;
      CAP_SH: begin
        if (stop_req)    state_nxt = STOP;
        else if (cont_q) state_nxt = ARMED;
        else             state_nxt = IDLE;
      end
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the registered bus
  // lines line up with the state they belong to.
  always_comb begin
    cs_nxt   = 1'b0;
    wn_nxt   = 1'b1;
    addr_nxt = 3'd0;
    data_nxt = 16'd0;
    case (state_nxt)
      CLR0, WR_ST: begin
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        addr_nxt = ADDR_STATUS;
      end
      WR_PL: begin
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        addr_nxt = ADDR_PERIODL;
        data_nxt = period_q[15:0];
      end
      WR_PH: begin
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        addr_nxt = ADDR_PERIODH;
        data_nxt = period_q[31:16];
      end
      WR_CTL: begin
        cs_nxt              = 1'b1;
        wn_nxt              = 1'b0;
        addr_nxt            = ADDR_CONTROL;
        data_nxt[CTL_ITO]   = P_IRQ_EN;
        data_nxt[CTL_CONT]  = cont_q;
        data_nxt[CTL_START] = 1'b1;
      end
      WR_SNAP: begin
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        addr_nxt = ADDR_SNAPL;
      end
      RD_SL: begin
        cs_nxt   = 1'b1;
        addr_nxt = ADDR_SNAPL;
      end
      RD_SH: begin
        cs_nxt   = 1'b1;
        addr_nxt = ADDR_SNAPH;
      end
      STOP: begin
        cs_nxt             = 1'b1;
        wn_nxt             = 1'b0;
        addr_nxt           = ADDR_CONTROL;
        data_nxt[CTL_STOP] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      period_q           <= 32'd0;
      cont_q             <= 1'b0;
      stop_pending       <= 1'b0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_write_n    <= 1'b1;
      avm.avm_address    <= 3'd0;
      avm.avm_writedata  <= 16'd0;
      busy               <= 1'b0;
      snap_value         <= 32'd0;
      snap_valid         <= 1'b0;
      event_count        <= 16'd0;
      cfg_error          <= 1'b0;
    end else begin
      state              <= state_nxt;
      avm.avm_chipselect <= cs_nxt;
      avm.avm_write_n    <= wn_nxt;
      avm.avm_address    <= addr_nxt;
      avm.avm_writedata  <= data_nxt;
      busy               <= (state_nxt != IDLE);
      cfg_error          <= (state == IDLE) && cmd_start && (cfg_period == 32'd0);
      snap_valid         <= (state == CAP_SH);

      if ((state == IDLE) && (state_nxt == CLR0)) begin
        period_q <= cfg_period;
        cont_q   <= cfg_continuous;
      end

      if (state_nxt == STOP)
        stop_pending <= 1'b0;
      else if (cmd_stop && (state inside {CLR0, WR_PL, WR_PH, WR_CTL,
                                          WR_ST, WR_SNAP, RD_SL, RD_SH, CAP_SH}))
        stop_pending <= 1'b1;

      if (state == RD_SH)
        snap_value[15:0] <= avm.avm_readdata;
      if (state == CAP_SH) begin
        snap_value[31:16] <= avm.avm_readdata;
        event_count       <= event_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/nios2system_timer_ctrl.md
NIOS2SYSTEM_TIMER_CTRL -- requirements
Module: nios2system_timer_ctrl

Interface
REQ-001 SHALL have parameter P_IRQ_EN, default 1, meaning the value written to the timer control ITO bit (bit 0).
REQ-002 SHALL have ports `clk  in  1` (the single clock) and `reset  in  1` (asynchronous, active-high).
REQ-003 SHALL have ports `cmd_start  in  1` (start pulse), `cmd_stop  in  1` (stop pulse), `cfg_period  in  32` (timer load value) and `cfg_continuous  in  1` (CONT bit).
REQ-004 SHALL have ports `avm_address  out  3`, `avm_chipselect  out  1`, `avm_write_n  out  1`, `avm_writedata  out  16` and `avm_readdata  in  16`; this is the Avalon-MM master to the 16-bit interval timer slave.
REQ-005 SHALL have ports `timer_irq  in  1` (timer slave irq), `busy  out  1`, `snap_value  out  32`, `snap_valid  out  1`, `event_count  out  16` and `cfg_error  out  1`.

Function
REQ-006 SHALL treat the slave as having no waitrequest: every write completes in the cycle it is driven.
REQ-007 SHALL treat read data as valid in cycle N+1 for an address driven in cycle N, with chipselect=1 and write_n=1.
REQ-008 SHALL use the following states: IDLE, CLR0, WR_PL, WR_PH, WR_CTL, ARMED, WR_ST, WR_SNAP, RD_SL, RD_SH, CAP_SH, STOP.
REQ-009 In IDLE, SHALL drive chipselect=0 and write_n=1.
REQ-010 In IDLE, on cmd_start with cfg_period!=0, SHALL latch cfg_period and cfg_continuous and go to CLR0.
REQ-011 In IDLE, on cmd_start with cfg_period==0, SHALL pulse cfg_error for 1 cycle and stay in IDLE.
REQ-012 SHALL perform these single-cycle writes, each advancing to the next state:
- CLR0: addr 0, data 0.
- WR_PL: addr 2, data period[15:0].
- WR_PH: addr 3, data period[31:16].
- WR_CTL: addr 1, data {12'b0, 1'b0, 1'b1, cont, P_IRQ_EN}.
REQ-013 In ARMED, SHALL drive no transaction.
REQ-014 In ARMED, on timer_irq=1, SHALL go to WR_ST; on cmd_stop=1, SHALL go to STOP.
REQ-015 If cmd_stop and timer_irq are both 1 in ARMED, cmd_stop SHALL win and the irq SHALL NOT be serviced.
REQ-016 SHALL perform these states in order:
- WR_ST: write addr 0, data 0 (clears TO).
- WR_SNAP: write addr 4, data 0 (captures snapshot).
- RD_SL: read addr 4.
- RD_SH: read addr 5 and capture avm_readdata into snap_value[15:0].
- CAP_SH: no transaction; capture avm_readdata into snap_value[31:16].
REQ-017 In CAP_SH, SHALL pulse snap_valid for 1 cycle and increment event_count by 1, wrapping 0xFFFF->0x0000.
REQ-018 After CAP_SH, SHALL go to ARMED if the latched cont=1, else to IDLE.
REQ-019 STOP SHALL write addr 1, data 0x0008 (STOP bit set, ITO=0) and then go to IDLE.
REQ-020 A cmd_stop received in CLR0..WR_CTL or WR_ST..CAP_SH SHALL set stop_pending.
REQ-021 With stop_pending set, the state after WR_CTL or CAP_SH SHALL be STOP, and stop_pending SHALL clear on entering STOP.
REQ-022 SHALL ignore cmd_start in every state except IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 All outputs SHALL be registered; snap_value SHALL hold its value between captures.

Reset
REQ-025 On reset, SHALL go to state IDLE.
REQ-026 On reset, SHALL set avm_chipselect=0, avm_write_n=1, avm_address=0 and avm_writedata=0.
REQ-027 On reset, SHALL set snap_value=0, snap_valid=0, event_count=0, cfg_error=0, busy=0 and stop_pending=0.
REQ-028 Reset asserted mid-sequence SHALL abort at once with no further bus cycles; the slave keeps its state.

Structure
REQ-029 A shared package nios2system_timer_pkg SHALL hold the state enum.
REQ-030 nios2system_timer_pkg SHALL hold register address constants (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5).
REQ-031 nios2system_timer_pkg SHALL hold control bit positions (ITO=0, CONT=1, START=2, STOP=3).
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 The bench SHALL cover: cfg_period=0x00001387, cont=0, cmd_start -> bus writes (0,0),(2,0x1387),(3,0),(1,0x0005) in 4 consecutive cycles.
REQ-034 The bench SHALL cover: in ARMED, irq=1 with slave snapshot 0x0002ABCD -> writes (0,0),(4,0), reads 4,5 -> snap_value=0x0002ABCD, snap_valid for 1 cycle, event_count=1, then IDLE.
REQ-035 The bench SHALL cover: cont=1 with 3 irqs -> 3 snap_valid pulses, event_count=3, state ARMED; then cmd_stop -> write (1,0x0008), then IDLE.
REQ-036 The bench SHALL cover: cmd_stop and irq in the same ARMED cycle -> no status write, write (1,0x0008), event_count unchanged.
REQ-037 The bench SHALL cover: cmd_stop during WR_PL -> sequence completes through WR_CTL, then write (1,0x0008); cmd_start while busy is ignored.
REQ-038 The bench SHALL cover: cfg_period=0 -> cfg_error for 1 cycle, no bus cycle; reset in RD_SL -> chipselect=0 next cycle, event_count=0.
